// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code encodings and FSM state encoding for seq_alu.
// SEQ_ALU_DIV_EN selects whether the DIV state exists.
package alu_pkg;

  localparam logic [3:0] ALU_ADD     = 4'b0000;
  localparam logic [3:0] ALU_SUB     = 4'b0001;
  localparam logic [3:0] ALU_MUL     = 4'b0010;
  localparam logic [3:0] ALU_DIVU    = 4'b0011;
  localparam logic [3:0] ALU_XOR     = 4'b0100;
  localparam logic [3:0] ALU_AND     = 4'b0101;
  localparam logic [3:0] ALU_OR      = 4'b0110;
  localparam logic [3:0] ALU_NOT     = 4'b0111;
  localparam logic [3:0] ALU_NOR     = 4'b1000;
  localparam logic [3:0] ALU_SLT     = 4'b1001;
  localparam logic [3:0] ALU_SLL     = 4'b1010;
  localparam logic [3:0] ALU_SRL     = 4'b1011;
  localparam logic [3:0] ALU_SRA     = 4'b1100;
  localparam logic [3:0] ALU_REMU    = 4'b1101;
  localparam logic [3:0] ALU_SLTU    = 4'b1110;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1,
    ST_DIV  = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RESP = 2'd1
  } state_e;
`endif

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/seq_alu_div.sv
// Restoring unsigned divider: one quotient bit per cycle, WIDTH cycles after start_i.
// Only instantiated when SEQ_ALU_DIV_EN is defined.
module seq_alu_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic             busy_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   shifted_d;
  logic [WIDTH:0]   diff_d;

  // Partial remainder shifted left with the next dividend bit; a borrow means "restore".
  assign shifted_d = {rem_q, quo_q[WIDTH-1]};
  assign diff_d    = shifted_d - {1'b0, dvs_q};

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      cnt_q  <= CW'(WIDTH);
      quo_q  <= dividend_i;
      rem_q  <= '0;
      dvs_q  <= divisor_i;
    end else if (busy_q) begin
      if (cnt_q != '0) begin
        rem_q <= diff_d[WIDTH] ? shifted_d[WIDTH-1:0] : diff_d[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], ~diff_d[WIDTH]};
        cnt_q <= cnt_q - CW'(1);
      end else begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done_o      = busy_q && (cnt_q == '0);
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle ops in one cycle, div/rem iterative.
// Define SEQ_ALU_DIV_EN to include the divider; otherwise divu/remu report err like an illegal op.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             err_q;
  logic [WIDTH-1:0] alu_res_d;
  logic             alu_err_d;
  logic [SHW-1:0]   shamt;

  assign shamt = srcb[SHW-1:0];

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    alu_res_d = '0;
    alu_err_d = 1'b0;
    case (op)
      ALU_ADD:  alu_res_d = srca + srcb;
      ALU_SUB:  alu_res_d = srca - srcb;
      ALU_MUL:  alu_res_d = srca * srcb;
      ALU_XOR:  alu_res_d = srca ^ srcb;
      ALU_AND:  alu_res_d = srca & srcb;
      ALU_OR:   alu_res_d = srca | srcb;
      ALU_NOT:  alu_res_d = ~srca;
      ALU_NOR:  alu_res_d = ~(srca | srcb);
      ALU_SLT:  alu_res_d = {{(WIDTH-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      ALU_SLL:  alu_res_d = srca << shamt;
      ALU_SRL:  alu_res_d = srca >> shamt;
      ALU_SRA:  alu_res_d = $unsigned($signed(srca) >>> shamt);
      ALU_SLTU: alu_res_d = {{(WIDTH-1){1'b0}}, (srca < srcb)};
`ifdef SEQ_ALU_DIV_EN
      // Only reached for a zero divisor; non-zero divisors go through the divider.
      ALU_DIVU: begin
        alu_res_d = '1;
        alu_err_d = 1'b1;
      end
      ALU_REMU: begin
        alu_res_d = srca;
        alu_err_d = 1'b1;
      end
`endif
      default:  alu_err_d = 1'b1;
    endcase
  end

`ifdef SEQ_ALU_DIV_EN
  logic             div_go;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic             rem_sel_q;

  assign div_go = in_valid && (state_q == ST_IDLE) && is_div_op(op) && (srcb != '0);

  seq_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (div_go),
    .dividend_i  (srca),
    .divisor_i   (srcb),
    .done_o      (div_done),
    .quotient_o  (div_quo),
    .remainder_o (div_rem)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      rem_sel_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
`ifdef SEQ_ALU_DIV_EN
            if (div_go) begin
              state_q   <= ST_DIV;
              rem_sel_q <= (op == ALU_REMU);
            end else
`endif
            begin
              state_q  <= ST_RESP;
              result_q <= alu_res_d;
              zero_q   <= (alu_res_d == '0);
              err_q    <= alu_err_d;
            end
          end
        end
`ifdef SEQ_ALU_DIV_EN
        ST_DIV: begin
          if (div_done) begin
            state_q  <= ST_RESP;
            result_q <= rem_sel_q ? div_rem : div_quo;
            zero_q   <= ((rem_sel_q ? div_rem : div_quo) == '0);
            err_q    <= 1'b0;
          end
        end
`endif
        ST_RESP: begin
          if (out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_RESP);
  assign result    = result_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_seq_alu.sv
// Randomized self-checking bench for seq_alu against an arithmetic reference model.
// Expectations follow SEQ_ALU_DIV_EN the same way the design build does.
module tb_seq_alu;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             err;

  int n_checks = 0;
  int n_errors = 0;

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .srca      (srca),
    .srcb      (srcb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: results from plain arithmetic on unsigned/signed integers.
  function automatic void model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e, output int lat);
    longint unsigned prod;
    int sh;
    e   = 1'b0;
    lat = 1;
    r   = '0;
    sh  = int'(b % 32);
    case (o)
      4'd0:  r = a + b;
      4'd1:  r = a - b;
      4'd2:  begin prod = longint'(a) * longint'(b); r = prod[31:0]; end
      4'd3, 4'd13: begin
`ifdef SEQ_ALU_DIV_EN
        if (b == 0) begin
          r = (o == 4'd3) ? 32'hFFFF_FFFF : a;
          e = 1'b1;
        end else begin
          r   = (o == 4'd3) ? a / b : a % b;
          lat = WIDTH + 1;
        end
`else
        e = 1'b1;
`endif
      end
      4'd4:  r = a ^ b;
      4'd5:  r = a & b;
      4'd6:  r = a | b;
      4'd7:  r = ~a;
      4'd8:  r = ~(a | b);
      4'd9:  r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd10: r = a << sh;
      4'd11: r = a >> sh;
      4'd12: r = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      4'd14: r = (a < b) ? 32'd1 : 32'd0;
      default: e = 1'b1;
    endcase
  endfunction

  task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] exp_r;
    logic        exp_e;
    int          exp_lat;
    int          lat;
    model(o, a, b, exp_r, exp_e, exp_lat);
    @(negedge clk);
    check($sformatf("%s.idle_ready", tag), in_ready, 1);
    in_valid = 1'b1;
    op = o;
    srca = a;
    srcb = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op   = 4'($urandom);
    srca = $urandom;
    srcb = $urandom;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      check($sformatf("%s.busy_ready", tag), in_ready, 0);
      @(negedge clk);
      lat++;
    end
    check($sformatf("%s.latency", tag), 64'(lat), 64'(exp_lat));
    check($sformatf("%s.result", tag), result, exp_r);
    check($sformatf("%s.zero", tag), zero, exp_r == 0);
    check($sformatf("%s.err", tag), err, exp_e);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check($sformatf("%s.hold_valid", tag), out_valid, 1);
      check($sformatf("%s.hold_result", tag), result, exp_r);
      check($sformatf("%s.hold_zero", tag), zero, exp_r == 0);
      check($sformatf("%s.hold_ready", tag), in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check($sformatf("%s.drained", tag), out_valid, 0);
    check($sformatf("%s.ready_after", tag), in_ready, 1);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    op = '0;
    srca = '0;
    srcb = '0;
    #12;
    check("reset.out_valid", out_valid, 0);
    check("reset.in_ready", in_ready, 1);
    check("reset.result", result, 0);
    check("reset.zero", zero, 0);
    check("reset.err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // out_ready with nothing pending must be ignored
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_out_ready.valid", out_valid, 0);
    check("idle_out_ready.ready", in_ready, 1);

    // reset in the middle of a divide
    @(negedge clk);
    in_valid = 1'b1;
    op = 4'd3;
    srca = 32'd100;
    srcb = 32'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_div_reset.out_valid", out_valid, 0);
    check("mid_div_reset.in_ready", in_ready, 1);
    check("mid_div_reset.result", result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sub_neg", 4'd1, 32'd3, 32'd5, 0);
    run_op("divu", 4'd3, 32'd100, 32'd7, 1);
    run_op("remu", 4'd13, 32'd100, 32'd7, 0);
    run_op("divu_zero", 4'd3, 32'd5, 32'd0, 0);
    run_op("remu_zero", 4'd13, 32'd9, 32'd0, 0);
    run_op("sra", 4'd12, 32'h8000_0000, 32'h24, 0);
    run_op("srl", 4'd11, 32'h8000_0000, 32'h24, 0);
    run_op("slt", 4'd9, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("sltu", 4'd14, 32'hFFFF_FFFF, 32'd1, 0);
    run_op("mul_bp", 4'd2, 32'h0001_0000, 32'h0001_0000, 10);
    run_op("illegal", 4'd15, 32'd123, 32'd456, 0);
    run_op("divu_big", 4'd3, 32'hFFFF_FFFF, 32'd1, 0);

    for (int i = 0; i < 300; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_a  = $urandom;
      case ($urandom_range(0, 3))
        0: r_b = 32'($urandom_range(0, 40));
        1: r_b = r_a;
        default: r_b = $urandom;
      endcase
      if ($urandom_range(0, 7) == 0) r_a = '0;
      run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, r_a, r_b, $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
